// File: rtl/switch_pkg.sv
// Shared defaults and helpers for the switch conditioning path.
// Imported by switch_debounce and switch_debounce_bit.
package switch_pkg;

    localparam int SW_WIDTH           = 10;
    localparam int SW_DEBOUNCE_CYCLES = 50000;
    localparam int SW_SYNC_STAGES     = 2;

    // The counter has to hold DEBOUNCE_CYCLES-1, and it must be at least one bit wide.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// Single-bit synchroniser, stability counter and clean-level flop.
// The accept_o output flags the cycle in which clean_o will take the new level on the next edge.
module switch_debounce_bit
    import switch_pkg::*;
#(
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic clean_o,
    output logic accept_o
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   sync_bit;
    logic                   accept;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // A single cycle of agreement resets the count, so short glitches never accumulate.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        accept  = 1'b0;
        if (sync_bit == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            clean_d = sync_bit;
            cnt_d   = '0;
            accept  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o  = clean_q;
    assign accept_o = accept;

endmodule

// File: rtl/switch_debounce.sv
// Debounces the slide-switch pins ahead of the switch PIO input port.
// Define SWITCH_DEBOUNCE_EDGE_EN to add edge pulses, sticky change flags and the irq output.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] sw_changed,
    input  logic [WIDTH-1:0] clr_changed,
    output logic             irq
);

    logic [WIDTH-1:0] accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (sw_raw[i]),
            .clean_o  (sw_clean[i]),
            .accept_o (accept[i])
        );
    end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic             irq_q, irq_d;

    // sw_clean still holds the old level here, which gives the edge direction.
    always_comb begin
        rise_d    = accept & ~sw_clean;
        fall_d    = accept & sw_clean;
        changed_d = (changed_q & ~clr_changed) | accept;
        irq_d     = |changed_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            irq_q     <= irq_d;
        end
    end

    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign sw_changed = changed_q;
    assign irq        = irq_q;
`else
    logic unused_edge;
    assign unused_edge = ^{accept, clr_changed};

    assign sw_rise    = '0;
    assign sw_fall    = '0;
    assign sw_changed = '0;
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce with WIDTH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Reference model: a level is accepted once the last DEBOUNCE_CYCLES synchronised samples all differ from it.
module tb_switch_debounce;

    localparam int W  = 10;
    localparam int SS = 2;
    localparam int DC = 4;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] clr_changed = '0;
    logic [W-1:0] sw_clean, sw_rise, sw_fall, sw_changed;
    logic         irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    switch_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw_raw      (sw_raw),
        .sw_clean    (sw_clean),
        .sw_rise     (sw_rise),
        .sw_fall     (sw_fall),
        .sw_changed  (sw_changed),
        .clr_changed (clr_changed),
        .irq         (irq)
    );

    // Reference model: raw delay line feeding a window of recent synchronised samples
    logic [W-1:0] m_raw_h [SS];
    logic [W-1:0] m_syn_h [DC-1];
    logic [W-1:0] m_clean, m_rise, m_fall, m_changed, m_mask;
    logic         m_irq;

    always_comb begin
        m_mask = m_raw_h[SS-1] ^ m_clean;
        for (int j = 0; j < DC-1; j++) m_mask = m_mask & (m_syn_h[j] ^ m_clean);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < SS; j++) m_raw_h[j] <= '0;
            for (int j = 0; j < DC-1; j++) m_syn_h[j] <= '0;
            m_clean   <= '0;
            m_rise    <= '0;
            m_fall    <= '0;
            m_changed <= '0;
            m_irq     <= 1'b0;
        end else begin
            m_raw_h[0] <= sw_raw;
            for (int j = 1; j < SS; j++) m_raw_h[j] <= m_raw_h[j-1];
            m_syn_h[0] <= m_raw_h[SS-1];
            for (int j = 1; j < DC-1; j++) m_syn_h[j] <= m_syn_h[j-1];
            m_clean   <= m_clean ^ m_mask;
            m_rise    <= m_mask & ~m_clean;
            m_fall    <= m_mask & m_clean;
            m_changed <= (m_changed & ~clr_changed) | m_mask;
            m_irq     <= |m_changed;
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        sw_raw = '0;
        clr_changed = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        edges(1);
        checks++; if (sw_clean !== '0) begin errors++; $display("FAIL reset_clean got %h want %h", sw_clean, 10'h000); end
        checks++; if (sw_rise !== '0) begin errors++; $display("FAIL reset_rise got %h want %h", sw_rise, 10'h000); end
        checks++; if (sw_fall !== '0) begin errors++; $display("FAIL reset_fall got %h want %h", sw_fall, 10'h000); end
        checks++; if (sw_changed !== '0) begin errors++; $display("FAIL reset_changed got %h want %h", sw_changed, 10'h000); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want %b", irq, 1'b0); end
    endtask

    task automatic test_single_rise;
        logic [W-1:0] e1;
        e1 = EN ? 10'h001 : 10'h000;
        sw_raw = 10'h001;
        edges(5);
        checks++; if (sw_clean !== 10'h000) begin errors++; $display("FAIL rise_early got %h want %h", sw_clean, 10'h000); end
        edges(1);
        checks++; if (sw_clean !== 10'h001) begin errors++; $display("FAIL rise_clean got %h want %h", sw_clean, 10'h001); end
        checks++; if (sw_rise !== e1) begin errors++; $display("FAIL rise_pulse got %h want %h", sw_rise, e1); end
        checks++; if (sw_fall !== 10'h000) begin errors++; $display("FAIL rise_nofall got %h want %h", sw_fall, 10'h000); end
        checks++; if (sw_changed !== e1) begin errors++; $display("FAIL rise_changed got %h want %h", sw_changed, e1); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early got %b want %b", irq, 1'b0); end
        edges(1);
        checks++; if (sw_rise !== 10'h000) begin errors++; $display("FAIL rise_pulse_end got %h want %h", sw_rise, 10'h000); end
        checks++; if (irq !== EN) begin errors++; $display("FAIL rise_irq got %b want %b", irq, EN); end
    endtask

    task automatic test_glitch;
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 0) sw_raw[3] = ~sw_raw[3];
            edges(1);
            checks++; if (sw_clean !== 10'h001) begin errors++; $display("FAIL glitch_clean cyc %0d got %h want %h", c, sw_clean, 10'h001); end
            checks++; if (sw_rise !== 10'h000) begin errors++; $display("FAIL glitch_rise cyc %0d got %h want %h", c, sw_rise, 10'h000); end
        end
        sw_raw[3] = 1'b1;
        edges(5);
        checks++; if (sw_clean !== 10'h001) begin errors++; $display("FAIL glitch_hold_early got %h want %h", sw_clean, 10'h001); end
        edges(1);
        checks++; if (sw_clean !== 10'h009) begin errors++; $display("FAIL glitch_hold_clean got %h want %h", sw_clean, 10'h009); end
        checks++; if (sw_rise !== (EN ? 10'h008 : 10'h000)) begin errors++; $display("FAIL glitch_hold_rise got %h want %h", sw_rise, (EN ? 10'h008 : 10'h000)); end
    endtask

    task automatic test_all_bits;
        logic [W-1:0] ea;
        ea = EN ? 10'h3FF : 10'h000;
        sw_raw = '0;
        edges(8);
        clr_changed = 10'h3FF;
        edges(1);
        clr_changed = '0;
        edges(2);
        checks++; if (sw_clean !== 10'h000) begin errors++; $display("FAIL all_pre_clean got %h want %h", sw_clean, 10'h000); end
        checks++; if (sw_changed !== 10'h000) begin errors++; $display("FAIL all_pre_changed got %h want %h", sw_changed, 10'h000); end
        sw_raw = 10'h3FF;
        edges(5);
        checks++; if (sw_clean !== 10'h000) begin errors++; $display("FAIL all_rise_early got %h want %h", sw_clean, 10'h000); end
        edges(1);
        checks++; if (sw_clean !== 10'h3FF) begin errors++; $display("FAIL all_rise_clean got %h want %h", sw_clean, 10'h3FF); end
        checks++; if (sw_rise !== ea) begin errors++; $display("FAIL all_rise_pulse got %h want %h", sw_rise, ea); end
        checks++; if (sw_changed !== ea) begin errors++; $display("FAIL all_rise_changed got %h want %h", sw_changed, ea); end
        sw_raw = 10'h000;
        edges(6);
        checks++; if (sw_clean !== 10'h000) begin errors++; $display("FAIL all_fall_clean got %h want %h", sw_clean, 10'h000); end
        checks++; if (sw_fall !== ea) begin errors++; $display("FAIL all_fall_pulse got %h want %h", sw_fall, ea); end
        checks++; if (sw_rise !== 10'h000) begin errors++; $display("FAIL all_fall_norise got %h want %h", sw_rise, 10'h000); end
    endtask

    task automatic test_clr_collision;
        logic [W-1:0] e1;
        e1 = EN ? 10'h001 : 10'h000;
        sw_raw = 10'h001;
        edges(8);
        clr_changed = 10'h3FF;
        edges(1);
        clr_changed = '0;
        edges(2);
        checks++; if (sw_changed !== 10'h000) begin errors++; $display("FAIL clr_pre_changed got %h want %h", sw_changed, 10'h000); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_pre_irq got %b want %b", irq, 1'b0); end
        sw_raw = 10'h000;
        edges(5);
        clr_changed = 10'h001;
        edges(1);
        clr_changed = '0;
        checks++; if (sw_clean !== 10'h000) begin errors++; $display("FAIL clr_coll_clean got %h want %h", sw_clean, 10'h000); end
        checks++; if (sw_fall !== e1) begin errors++; $display("FAIL clr_coll_fall got %h want %h", sw_fall, e1); end
        checks++; if (sw_changed !== e1) begin errors++; $display("FAIL clr_coll_changed got %h want %h", sw_changed, e1); end
        edges(1);
        clr_changed = 10'h001;
        edges(1);
        clr_changed = '0;
        checks++; if (sw_changed !== 10'h000) begin errors++; $display("FAIL clr_alone_changed got %h want %h", sw_changed, 10'h000); end
        checks++; if (irq !== EN) begin errors++; $display("FAIL clr_alone_irq_hold got %b want %b", irq, EN); end
        edges(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_alone_irq_drop got %b want %b", irq, 1'b0); end
    endtask

    task automatic test_async_reset;
        sw_raw = 10'h2F0;
        edges(8);
        checks++; if (sw_clean !== 10'h2F0) begin errors++; $display("FAIL arst_pre_clean got %h want %h", sw_clean, 10'h2F0); end
        sw_raw = 10'h2F1;
        edges(5);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (sw_clean !== '0) begin errors++; $display("FAIL arst_clean got %h want %h", sw_clean, 10'h000); end
        checks++; if (sw_rise !== '0) begin errors++; $display("FAIL arst_rise got %h want %h", sw_rise, 10'h000); end
        checks++; if (sw_fall !== '0) begin errors++; $display("FAIL arst_fall got %h want %h", sw_fall, 10'h000); end
        checks++; if (sw_changed !== '0) begin errors++; $display("FAIL arst_changed got %h want %h", sw_changed, 10'h000); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq got %b want %b", irq, 1'b0); end
        @(negedge clk);
        reset_n = 1'b1;
        edges(5);
        checks++; if (sw_clean !== 10'h000) begin errors++; $display("FAIL arst_relat_early got %h want %h", sw_clean, 10'h000); end
        edges(1);
        checks++; if (sw_clean !== 10'h2F1) begin errors++; $display("FAIL arst_relat_clean got %h want %h", sw_clean, 10'h2F1); end
        checks++; if (sw_rise !== (EN ? 10'h2F1 : 10'h000)) begin errors++; $display("FAIL arst_relat_rise got %h want %h", sw_rise, (EN ? 10'h2F1 : 10'h000)); end
    endtask

    task automatic test_random;
        logic [W-1:0] nr;
        logic [W-1:0] e_rise, e_fall, e_chg;
        logic         e_irq;
        for (int c = 0; c < 400; c++) begin
            e_rise = EN ? m_rise : '0;
            e_fall = EN ? m_fall : '0;
            e_chg  = EN ? m_changed : '0;
            e_irq  = EN ? m_irq : 1'b0;
            checks++; if (sw_clean !== m_clean) begin errors++; $display("FAIL rnd_clean cyc %0d got %h want %h", c, sw_clean, m_clean); end
            checks++; if (sw_rise !== e_rise) begin errors++; $display("FAIL rnd_rise cyc %0d got %h want %h", c, sw_rise, e_rise); end
            checks++; if (sw_fall !== e_fall) begin errors++; $display("FAIL rnd_fall cyc %0d got %h want %h", c, sw_fall, e_fall); end
            checks++; if (sw_changed !== e_chg) begin errors++; $display("FAIL rnd_changed cyc %0d got %h want %h", c, sw_changed, e_chg); end
            checks++; if (irq !== e_irq) begin errors++; $display("FAIL rnd_irq cyc %0d got %b want %b", c, irq, e_irq); end
            nr = sw_raw;
            for (int b = 0; b < W; b++) if ($urandom_range(0, 5) == 0) nr[b] = ~nr[b];
            sw_raw = nr;
            clr_changed = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            edges(1);
        end
        clr_changed = '0;
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_glitch();
        test_all_bits();
        test_clr_collision();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
